// File: rtl/seq_shifter8.sv
// seq_shifter8: registered sequential shifter, one bit position per clock.
//
// A start request sampled in IDLE either loads d_in, completes immediately
// (shift by 0), or enters SHIFT. In SHIFT the result register moves one bit
// per edge according to the latched operation until the latched count runs
// out. DONE then raises a one-cycle done pulse and returns to IDLE.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   start    request strobe, sampled only in IDLE
//   op       000 NOP, 001 LOAD, 010 LSL, 011 LSR, 100 ASR, 101 ROL, 110 ROR, 111 NOP
//   shamt    shift amount, sampled with start
//   d_in     load data, sampled with start when op = LOAD
//   d_out    registered result; also the operand of the next operation
//   busy     high while shifting
//   done     one-cycle completion pulse
module seq_shifter8 #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [AMT_W-1:0] shamt,
   input  logic [WIDTH-1:0] d_in,
   output logic [WIDTH-1:0] d_out,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_LOAD = 3'b001;
   localparam logic [2:0] OP_LSL  = 3'b010;
   localparam logic [2:0] OP_LSR  = 3'b011;
   localparam logic [2:0] OP_ASR  = 3'b100;
   localparam logic [2:0] OP_ROL  = 3'b101;
   localparam logic [2:0] OP_ROR  = 3'b110;

   // Per-bit source selector encoding for the 4:1 mux
   localparam logic [1:0] SEL_HOLD  = 2'b00;
   localparam logic [1:0] SEL_LEFT  = 2'b01;  // take bit i-1 (value moves up)
   localparam logic [1:0] SEL_RIGHT = 2'b10;  // take bit i+1 (value moves down)
   localparam logic [1:0] SEL_FILL  = 2'b11;  // fill or wrap-around bit

   localparam logic [AMT_W-1:0] CNT_ZERO = {AMT_W{1'b0}};
   localparam logic [AMT_W-1:0] CNT_ONE  = {{(AMT_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [WIDTH-1:0] d_out_q, d_out_d;
   logic [2:0]       op_q, op_d;
   logic [AMT_W-1:0] count_q, count_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             move_left;
   logic             move_right;
   logic             fill_bit;
   logic [WIDTH-1:0] from_left;
   logic [WIDTH-1:0] from_right;
   logic [WIDTH-1:0] shift_v;
   logic [1:0]       sel;

   // mx4-style selection: s chooses among d0..d3
   function automatic logic mx4(input logic [1:0] s, input logic d3, input logic d2,
                                input logic d1, input logic d0);
      logic y;
      case (s)
         2'b00:   y = d0;
         2'b01:   y = d1;
         2'b10:   y = d2;
         2'b11:   y = d3;
         default: y = d0;
      endcase
      return y;
   endfunction

   // Decode the latched operation into direction and the bit entering the vacated end
   always_comb begin
      move_left  = 1'b0;
      move_right = 1'b0;
      fill_bit   = 1'b0;
      case (op_q)
         OP_LSL: begin move_left  = 1'b1; fill_bit = 1'b0;             end
         OP_LSR: begin move_right = 1'b1; fill_bit = 1'b0;             end
         OP_ASR: begin move_right = 1'b1; fill_bit = d_out_q[WIDTH-1]; end
         OP_ROL: begin move_left  = 1'b1; fill_bit = d_out_q[WIDTH-1]; end
         OP_ROR: begin move_right = 1'b1; fill_bit = d_out_q[0];       end
         default: begin move_left = 1'b0; move_right = 1'b0; fill_bit = 1'b0; end
      endcase
   end

   // One-position shift built from a 4:1 mux per bit; the end bit uses the fill input
   always_comb begin
      from_left  = {d_out_q[WIDTH-2:0], 1'b0};
      from_right = {1'b0, d_out_q[WIDTH-1:1]};
      shift_v    = d_out_q;
      sel        = SEL_HOLD;
      for (int i = 0; i < WIDTH; i++) begin
         if (move_left) begin
            sel = (i == 0) ? SEL_FILL : SEL_LEFT;
         end else if (move_right) begin
            sel = (i == WIDTH - 1) ? SEL_FILL : SEL_RIGHT;
         end else begin
            sel = SEL_HOLD;
         end
         shift_v[i] = mx4(sel, fill_bit, from_right[i], from_left[i], d_out_q[i]);
      end
   end

   // Next-state, datapath and output-flag decode
   always_comb begin
      state_d = state_q;
      d_out_d = d_out_q;
      op_d    = op_q;
      count_d = count_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               case (op)
                  OP_LOAD: begin
                     d_out_d = d_in;
                     state_d = ST_DONE;
                  end
                  OP_LSL, OP_LSR, OP_ASR, OP_ROL, OP_ROR: begin
                     if (shamt == CNT_ZERO) begin
                        state_d = ST_DONE;
                     end else begin
                        op_d    = op;
                        count_d = shamt;
                        state_d = ST_SHIFT;
                     end
                  end
                  default: begin
                     state_d = ST_IDLE;   // NOP encodings
                  end
               endcase
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            d_out_d = shift_v;
            count_d = count_q - CNT_ONE;
            if (count_q == CNT_ONE) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_SHIFT;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Flags are registered from the next state so they align with state_q
      busy_d = (state_d == ST_SHIFT);
      done_d = (state_d == ST_DONE);
   end

   // State, datapath and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         d_out_q <= {WIDTH{1'b0}};
         op_q    <= OP_NOP;
         count_q <= CNT_ZERO;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         d_out_q <= d_out_d;
         op_q    <= op_d;
         count_q <= count_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign d_out = d_out_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule

// File: tb/tb_seq_shifter8.sv
// Testbench for seq_shifter8: table of LOAD-then-operate vectors plus
// hand-written sequences for trace, ignored starts, NOP, shift-by-0,
// back-to-back operation and asynchronous reset mid-shift.
module tb_seq_shifter8;

   logic       clk;
   logic       reset_n;
   logic       start;
   logic [2:0] op;
   logic [2:0] shamt;
   logic [7:0] d_in;
   logic [7:0] d_out;
   logic       busy;
   logic       done;

   int checks;
   int failures;

   localparam logic [2:0] NOP  = 3'b000;
   localparam logic [2:0] LOAD = 3'b001;
   localparam logic [2:0] LSL  = 3'b010;
   localparam logic [2:0] LSR  = 3'b011;
   localparam logic [2:0] ASR  = 3'b100;
   localparam logic [2:0] ROL  = 3'b101;
   localparam logic [2:0] ROR  = 3'b110;
   localparam logic [2:0] NOP7 = 3'b111;

   typedef struct {
      string      name;
      logic [7:0] seed;
      logic [2:0] op;
      logic [2:0] shamt;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs[11];

   seq_shifter8 dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .op      (op),
      .shamt   (shamt),
      .d_in    (d_in),
      .d_out   (d_out),
      .busy    (busy),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called at a negedge in IDLE. Issues one request and waits (bounded) for done.
   task automatic run_op(input logic [2:0] o, input logic [2:0] n, input logic [7:0] d,
                         output int busy_n, output bit got_done);
      start = 1'b1; op = o; shamt = n; d_in = d;
      @(negedge clk);
      start = 1'b0; op = NOP; shamt = 3'd0; d_in = 8'h00;
      busy_n = 0;
      got_done = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (done) begin
            got_done = 1'b1;
            break;
         end
         if (busy) busy_n++;
         @(negedge clk);
      end
   endtask

   // Runs one operation and checks result, busy length and single done pulse.
   task automatic do_and_check(input string name, input logic [2:0] o, input logic [2:0] n,
                               input logic [7:0] d, input logic [7:0] exp);
      int busy_n;
      bit got_done;
      run_op(o, n, d, busy_n, got_done);
      check_val({name, "_done_seen"}, int'(got_done), 1);
      check_val({name, "_busy_cycles"}, busy_n, (o == LOAD) ? 0 : int'(n));
      check_val({name, "_dout"}, int'(d_out), int'(exp));
      @(negedge clk);
      check_val({name, "_done_one_cycle"}, int'(done), 0);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      reset_n = 1'b0;
      start = 1'b0; op = NOP; shamt = 3'd0; d_in = 8'h00;

      vecs[0]  = '{"asr3_96", 8'h96, ASR, 3'd3, 8'hF2};
      vecs[1]  = '{"lsl3_96", 8'h96, LSL, 3'd3, 8'hB0};
      vecs[2]  = '{"ror3_96", 8'h96, ROR, 3'd3, 8'hD2};
      vecs[3]  = '{"rol1_81", 8'h81, ROL, 3'd1, 8'h03};
      vecs[4]  = '{"lsr7_96", 8'h96, LSR, 3'd7, 8'h01};
      vecs[5]  = '{"asr7_96", 8'h96, ASR, 3'd7, 8'hFF};
      vecs[6]  = '{"lsr1_5a", 8'h5A, LSR, 3'd1, 8'h2D};
      vecs[7]  = '{"ror1_01", 8'h01, ROR, 3'd1, 8'h80};
      vecs[8]  = '{"lsl7_ff", 8'hFF, LSL, 3'd7, 8'h80};
      vecs[9]  = '{"asr2_40", 8'h40, ASR, 3'd2, 8'h10};
      vecs[10] = '{"ror0_5a", 8'h5A, ROR, 3'd0, 8'h5A};

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check_val("rst_dout", int'(d_out), 0);
      check_val("rst_busy", int'(busy), 0);
      check_val("rst_done", int'(done), 0);
      reset_n = 1'b1;
      @(negedge clk);

      // Table-driven: load seed, then operate
      for (int i = 0; i < 11; i++) begin
         do_and_check({vecs[i].name, "_load"}, LOAD, 3'd0, vecs[i].seed, vecs[i].seed);
         do_and_check(vecs[i].name, vecs[i].op, vecs[i].shamt, 8'h00, vecs[i].exp);
      end

      // ASR 3 trace with ignored mid-shift requests
      do_and_check("trace_load", LOAD, 3'd0, 8'h96, 8'h96);
      start = 1'b1; op = ASR; shamt = 3'd3; d_in = 8'h00;
      @(negedge clk);
      check_val("trace_s0", int'(d_out), 8'h96);
      check_val("trace_busy0", int'(busy), 1);
      start = 1'b1; op = LOAD; d_in = 8'hFF; shamt = 3'd5;
      @(negedge clk);
      check_val("trace_s1", int'(d_out), 8'hCB);
      check_val("trace_busy1", int'(busy), 1);
      shamt = 3'd0; op = LSL;
      @(negedge clk);
      check_val("trace_s2", int'(d_out), 8'hE5);
      check_val("trace_busy2", int'(busy), 1);
      start = 1'b0; op = NOP; d_in = 8'h00;
      @(negedge clk);
      check_val("trace_s3", int'(d_out), 8'hF2);
      check_val("trace_done", int'(done), 1);
      check_val("trace_busy3", int'(busy), 0);
      @(negedge clk);
      check_val("trace_done_low", int'(done), 0);
      check_val("trace_hold", int'(d_out), 8'hF2);

      // NOP requests: no done, d_out holds
      start = 1'b1; op = NOP;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_val("nop0_done", int'(done), 0);
      end
      op = NOP7;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_val("nop7_done", int'(done) | int'(busy), 0);
      end
      start = 1'b0; op = NOP;
      check_val("nop_hold", int'(d_out), 8'hF2);

      // Start in DONE cycle ignored; start in following IDLE accepted
      start = 1'b1; op = LOAD; d_in = 8'h96;
      @(negedge clk);
      check_val("dstart_done", int'(done), 1);
      start = 1'b1; op = LOAD; d_in = 8'hFF;
      @(negedge clk);
      start = 1'b0; op = NOP; d_in = 8'h00;
      check_val("dstart_ignored_done", int'(done), 0);
      check_val("dstart_ignored_dout", int'(d_out), 8'h96);
      do_and_check("idle_start", LOAD, 3'd0, 8'h33, 8'h33);

      // Back-to-back, result feeds the next operation
      do_and_check("b2b_load", LOAD, 3'd0, 8'h01, 8'h01);
      do_and_check("b2b_rol7", ROL, 3'd7, 8'h00, 8'h80);
      do_and_check("b2b_rol1", ROL, 3'd1, 8'h00, 8'h01);

      // Asynchronous reset mid-shift
      do_and_check("ar_load", LOAD, 3'd0, 8'hA5, 8'hA5);
      start = 1'b1; op = LSL; shamt = 3'd7;
      @(negedge clk);
      start = 1'b0; op = NOP; shamt = 3'd0;
      @(negedge clk);
      check_val("ar_busy_before", int'(busy), 1);
      #2 reset_n = 1'b0;
      #1;
      check_val("ar_dout", int'(d_out), 0);
      check_val("ar_busy", int'(busy), 0);
      check_val("ar_done", int'(done), 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check_val("ar_idle_busy", int'(busy), 0);
      check_val("ar_idle_done", int'(done), 0);
      check_val("ar_idle_dout", int'(d_out), 0);
      do_and_check("ar_recover", LOAD, 3'd0, 8'h3C, 8'h3C);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
